// File: rtl/turing_pkg.sv
// Shared definitions for the single-tape unary Turing machines (adder and
// subtractor): control state encoding, head move codes, default tape width
// and the head-width helper.
package turing_pkg;

  localparam int TAPE_W_DEF = 10;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FIND_A  = 4'd1,
    RUN_A   = 4'd2,
    RUN_B   = 4'd3,
    ERASE_B = 4'd4,
    BACK    = 4'd5,
    SEEK_A  = 4'd6,
    FWD     = 4'd7,
    DONE    = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    STAY  = 2'd1,
    RIGHT = 2'd2
  } move_t;

  // Width of a head index for a tape of w cells (at least one bit).
  function automatic int head_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/turing_tape.sv
// Tape storage and read/write head for the unary Turing machines.
// Ports:
//   clk, rstn         clock (rising edge), asynchronous active-high reset
//   i_load, i_din     load a fresh tape image and park the head at cell 0
//   i_wr, i_wdata     write i_wdata into the cell under the head
//   i_move            head move for this step (LEFT/STAY/RIGHT)
//   o_rd              bit under the head
//   o_head            head position
//   o_image           whole tape image
module turing_tape
  import turing_pkg::*;
#(
  parameter int  TAPE_W = TAPE_W_DEF,
  localparam int HW     = head_w(TAPE_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load,
  input  logic [TAPE_W-1:0] i_din,
  input  logic              i_wr,
  input  logic              i_wdata,
  input  move_t             i_move,
  output logic              o_rd,
  output logic [HW-1:0]     o_head,
  output logic [TAPE_W-1:0] o_image
);

  localparam logic [HW-1:0] HEAD_MAX = HW'(TAPE_W - 1);

  logic [TAPE_W-1:0] r_tape;
  logic [HW-1:0]     r_head;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_tape <= '0;
      r_head <= '0;
    end else if (i_load) begin
      r_tape <= i_din;
      r_head <= '0;
    end else begin
      if (i_wr) r_tape[r_head] <= i_wdata;
      // Moves are clamped here as a last line of defence; the controller
      // already guards every move at the tape ends.
      case (i_move)
        LEFT:    if (r_head != '0)       r_head <= r_head - 1'b1;
        RIGHT:   if (r_head != HEAD_MAX) r_head <= r_head + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_rd    = r_tape[r_head];
  assign o_head  = r_head;
  assign o_image = r_tape;

endmodule

// File: rtl/turing_unary_sub.sv
// Unary subtractor Turing machine: tape holds m ones, a 0 separator, then
// n ones. Each round erases the rightmost 1 of B and then the rightmost 1
// of A, leaving m-n ones in place. Running out of A ones while B still has
// ones flags err; a step watchdog also forces DONE with err.
// Ports:
//   clk, rstn   clock (rising edge), asynchronous active-high reset
//   start, din  load din and run (accepted only in IDLE or DONE)
//   busy        machine stepping
//   done        run finished, held until the next accepted start
//   err         underflow or watchdog expiry, valid with done
//   dout        live tape image
//   head        head position
//   steps       busy cycles of the current run
module turing_unary_sub
  import turing_pkg::*;
#(
  parameter int  TAPE_W    = TAPE_W_DEF,
  parameter int  MAX_STEPS = 255,
  localparam int HW        = head_w(TAPE_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [TAPE_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TAPE_W-1:0] dout,
  output logic [HW-1:0]     head,
  output logic [7:0]        steps
);

  localparam logic [HW-1:0] HEAD_MAX  = HW'(TAPE_W - 1);
  localparam logic [8:0]    WD_LIMIT  = 9'(MAX_STEPS);
  localparam logic [7:0]    STEPS_SAT = 8'(MAX_STEPS);

  state_t          r_state;
  state_t          w_state_next;
  logic [HW-1:0]   r_a_start;
  logic [HW-1:0]   r_sep;
  logic [7:0]      r_steps;
  logic            r_err;

  logic            w_load;
  logic            w_wr;
  logic            w_wdata;
  move_t           w_move;
  logic            w_set_a_start;
  logic            w_set_sep;
  logic            w_err_set;
  logic            w_rd;
  logic            w_at_end;
  logic            w_wd_hit;
  logic [HW-1:0]   w_head;
  logic [TAPE_W-1:0] w_image;

  turing_tape #(.TAPE_W(TAPE_W)) u_tape (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_din   (din),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_move  (w_move),
    .o_rd    (w_rd),
    .o_head  (w_head),
    .o_image (w_image)
  );

  assign busy     = (r_state != IDLE) && (r_state != DONE);
  assign done     = (r_state == DONE);
  assign err      = r_err;
  assign dout     = w_image;
  assign head     = w_head;
  assign steps    = r_steps;
  assign w_at_end = (w_head == HEAD_MAX);
  // The busy cycle that would bring steps up to the limit is the last one.
  assign w_wd_hit = busy && (({1'b0, r_steps} + 9'd1) >= WD_LIMIT);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_a_start <= '0;
      r_sep     <= '0;
      r_steps   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_set_a_start) r_a_start <= w_head;
      if (w_set_sep)     r_sep     <= w_head;
      if (w_load) begin
        r_steps <= '0;
        r_err   <= 1'b0;
      end else begin
        if (busy && (r_steps != STEPS_SAT)) r_steps <= r_steps + 8'd1;
        if (w_err_set) r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_wr          = 1'b0;
    w_wdata       = 1'b0;
    w_move        = STAY;
    w_set_a_start = 1'b0;
    w_set_sep     = 1'b0;
    w_err_set     = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = FIND_A;
        end
      end
      FIND_A: begin
        if (w_rd) begin
          w_set_a_start = 1'b1;
          w_state_next  = RUN_A;
        end else if (w_at_end) begin
          w_state_next = DONE;
        end else begin
          w_move = RIGHT;
        end
      end
      RUN_A: begin
        if (w_rd) begin
          if (w_at_end) w_state_next = DONE;
          else          w_move       = RIGHT;
        end else begin
          w_set_sep = 1'b1;
          if (w_at_end) begin
            w_state_next = DONE;
          end else begin
            w_move       = RIGHT;
            w_state_next = RUN_B;
          end
        end
      end
      RUN_B: begin
        if (w_rd) begin
          if (!w_at_end) begin
            w_move = RIGHT;
          end else begin
            // B reaches the last cell: erase it here, no ERASE_B visit.
            w_wr         = 1'b1;
            w_move       = LEFT;
            w_state_next = BACK;
          end
        end else if (w_head == r_sep + 1'b1) begin
          w_state_next = DONE;
        end else begin
          w_move       = LEFT;
          w_state_next = ERASE_B;
        end
      end
      ERASE_B: begin
        w_wr         = 1'b1;
        w_move       = LEFT;
        w_state_next = BACK;
      end
      BACK: begin
        w_move = LEFT;
        if (w_head == r_sep) w_state_next = SEEK_A;
      end
      SEEK_A: begin
        if (w_rd) begin
          w_wr         = 1'b1;
          w_move       = RIGHT;
          w_state_next = FWD;
        end else if (w_head == r_a_start) begin
          w_err_set    = 1'b1;
          w_state_next = DONE;
        end else begin
          w_move = LEFT;
        end
      end
      FWD: begin
        w_move = RIGHT;
        if (w_head == r_sep) w_state_next = RUN_B;
      end
      default: w_state_next = IDLE;
    endcase

    // Watchdog overrides whatever the machine wanted to do on this step.
    if (w_wd_hit) begin
      w_state_next = DONE;
      w_err_set    = 1'b1;
      w_wr         = 1'b0;
      w_move       = STAY;
    end
  end

endmodule

// File: tb/tb_turing_unary_sub.sv
module tb_turing_unary_sub;
  localparam int W  = 10;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  din = '0;
  logic          busy, done, err;
  logic [W-1:0]  dout;
  logic [HW-1:0] head;
  logic [7:0]    steps;

  logic          start_wd = 1'b0;
  logic [W-1:0]  din_wd = '0;
  logic          wd_busy, wd_done, wd_err;
  logic [W-1:0]  wd_dout;
  logic [HW-1:0] wd_head;
  logic [7:0]    wd_steps;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] cur_din = '0;

  always #5 clk = ~clk;

  turing_unary_sub #(.TAPE_W(W), .MAX_STEPS(255)) dut (
    .clk(clk), .rstn(rstn), .start(start), .din(din),
    .busy(busy), .done(done), .err(err), .dout(dout), .head(head), .steps(steps)
  );

  turing_unary_sub #(.TAPE_W(W), .MAX_STEPS(8)) dut_wd (
    .clk(clk), .rstn(rstn), .start(start_wd), .din(din_wd),
    .busy(wd_busy), .done(wd_done), .err(wd_err), .dout(wd_dout), .head(wd_head), .steps(wd_steps)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: parse the tape into A (first run of ones), separator, B (run
  // after it); the result is m-n ones with B erased from its right end and A
  // from its right end. Busy-cycle count comes from the walk lengths of each
  // round (head sweeps across B, back over the separator, into A and back).
  task automatic model(input logic [W-1:0] d, input int maxs,
                       output logic [W-1:0] q, output logic e, output int t,
                       output int h, output bit v);
    int a, s, m, n, rem, tn;
    q = d; e = 1'b0; a = -1; s = -1; tn = 0; h = 0;
    for (int i = 0; i < W; i++) if (d[i] && a < 0) a = i;
    if (a < 0) begin
      tn = W; h = W - 1;
    end else begin
      for (int i = a; i < W; i++) if (!d[i] && s < 0) s = i;
      if (s < 0) begin
        tn = W + 1; h = W - 1;
      end else if (s == W - 1) begin
        tn = a + 2 + (s - a); h = W - 1;
      end else begin
        m = s - a; n = 0;
        while (s + 1 + n < W && d[s + 1 + n]) n++;
        tn = a + 2 + m;
        for (int k = 0; k <= W; k++) begin
          rem = n - k;
          if (rem == 0) begin tn += 1; h = s + 1; break; end
          tn += (s + rem == W - 1) ? 2 * rem : 2 * rem + 2;
          q[s + rem] = 1'b0;
          if (m - k == 0) begin tn += m; e = 1'b1; h = a; break; end
          q[s - 1 - k] = 1'b0;
          tn += 2 * (k + 1);
        end
      end
    end
    if (tn >= maxs) begin
      e = 1'b1; t = maxs; v = (tn == maxs);
    end else begin
      t = tn; v = 1'b1;
    end
  endtask

  // Per-cycle checks on the main instance.
  bit   m_prev_busy = 1'b0, m_prev_done = 1'b0;
  int   m_prev_steps = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      chk("head_range", {31'd0, (head <= HW'(W - 1))}, 32'd1);
      if (busy || done) chk("erase_only", 32'(dout & ~cur_din), 32'd0);
      if (m_prev_busy && (busy || done)) chk("steps_inc", 32'(steps), 32'(m_prev_steps + 1));
      if (m_prev_done && done) chk("steps_hold", 32'(steps), 32'(m_prev_steps));
    end
    m_prev_busy  = busy;
    m_prev_done  = done;
    m_prev_steps = int'(steps);
  end

  task automatic run(input logic [W-1:0] d);
    logic [W-1:0] eq; logic ee; int et, eh, cyc; bit ev;
    model(d, 255, eq, ee, et, eh, ev);
    din = d; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cur_din = d;
    cyc = 0;
    while (done !== 1'b1 && cyc < 600) begin @(posedge clk); #1; cyc++; end
    chk("run_done", {31'd0, done}, 32'd1);
    chk("run_err", {31'd0, err}, {31'd0, ee});
    chk("run_steps", 32'(steps), 32'(et));
    if (ev) begin
      chk("run_dout", 32'(dout), 32'(eq));
      chk("run_head", 32'(head), 32'(eh));
    end
    $display("run din=%03h dout=%03h err=%0b steps=%0d head=%0d (exp dout=%03h err=%0b steps=%0d)",
             d, dout, err, steps, head, eq, ee, et);
  endtask

  initial begin : main
    logic [W-1:0] q, d; logic e; int t, h, a, m, n, cyc; bit v;

    #2 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_head", 32'(head), 32'd0);
    chk("rst_steps", 32'(steps), 32'd0);
    rstn = 1'b0;
    @(posedge clk); #1;

    // Pin the reference model with hand-derived values.
    model(10'h0DE, 255, q, e, t, h, v);
    chk("model_0DE_dout", 32'(q), 32'h006);
    chk("model_0DE_steps", 32'(t), 32'd24);
    model(10'h00D, 255, q, e, t, h, v);
    chk("model_00D_err", {31'd0, e}, 32'd1);
    chk("model_00D_steps", 32'(t), 32'd16);
    model(10'h2FF, 255, q, e, t, h, v);
    chk("model_2FF_dout", 32'(q), 32'h07F);
    chk("model_2FF_steps", 32'(t), 32'd15);

    run(10'h0DE);
    chk("t_0DE_dout", 32'(dout), 32'h006);
    chk("t_0DE_err", {31'd0, err}, 32'd0);
    run(10'h01B);
    chk("t_01B_dout", 32'(dout), 32'h000);
    chk("t_01B_err", {31'd0, err}, 32'd0);
    run(10'h007);
    chk("t_007_dout", 32'(dout), 32'h007);
    chk("t_007_err", {31'd0, err}, 32'd0);
    run(10'h00D);
    chk("t_00D_err", {31'd0, err}, 32'd1);
    chk("t_00D_bit0", {31'd0, dout[0]}, 32'd0);
    run(10'h2FF);
    chk("t_2FF_dout", 32'(dout), 32'h07F);
    chk("t_2FF_err", {31'd0, err}, 32'd0);
    run(10'h000);
    chk("t_000_dout", 32'(dout), 32'h000);

    // Watchdog instance, with a start pulse during the run that must be ignored.
    din_wd = 10'h0DE; start_wd = 1'b1;
    @(posedge clk); #1; start_wd = 1'b0;
    repeat (3) @(posedge clk);
    #1; din_wd = 10'h01B; start_wd = 1'b1;
    @(posedge clk); #1; start_wd = 1'b0;
    chk("wd_ignore_busy", {31'd0, wd_busy}, 32'd1);
    chk("wd_ignore_steps", 32'(wd_steps), 32'd4);
    cyc = 0;
    while (wd_done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("wd_done", {31'd0, wd_done}, 32'd1);
    chk("wd_steps", 32'(wd_steps), 32'd8);
    chk("wd_err", {31'd0, wd_err}, 32'd1);
    chk("wd_dout", 32'(wd_dout), 32'h0DE);
    $display("watchdog din=0DE dout=%03h err=%0b steps=%0d", wd_dout, wd_err, wd_steps);

    // Reset in the middle of a run, then a clean run.
    din = 10'h0DE; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cur_din = 10'h0DE;
    repeat (10) @(posedge clk);
    #1; rstn = 1'b1;
    #2;
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_steps", 32'(steps), 32'd0);
    rstn = 1'b0;
    $display("midrun reset dout=%03h busy=%0b done=%0b", dout, busy, done);
    @(posedge clk); #1;
    run(10'h0DE);
    chk("after_rst_dout", 32'(dout), 32'h006);

    // Randomised tapes: mostly well-formed A/sep/B, some raw words.
    for (int it = 0; it < 40; it++) begin
      d = W'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        a = $urandom_range(0, 3); m = $urandom_range(1, 4); n = $urandom_range(0, 4);
        for (int i = 0; i < W; i++) begin
          if (i < a) d[i] = 1'b0;
          else if (i < a + m) d[i] = 1'b1;
          else if (i == a + m) d[i] = 1'b0;
          else if (i <= a + m + n) d[i] = 1'b1;
          else if (i == a + m + n + 1) d[i] = 1'b0;
        end
      end
      run(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
